segment_scheduler: RTL and testbench
====================================

Name: segment_scheduler

Overview:
- Parametrised successor to the combinational segment-size calculation in the send pipe.
- Accepts one send request per flow: flow id plus trail/lead buffer pointers.
- Walks the outstanding byte range and emits a sequence of segments, each with start pointer and size, under valid/ready handshakes.
- Sits between the send-buffer pointer tracker and the packet header assembler.

Parameters:
- PTR_W, 15: pointer MSB index; pointers are PTR_W+1 bits and wrap modulo 2^(PTR_W+1).
- MSS_BYTES, 1024: maximum segment size. Must be a multiple of 2^ALIGN_LOG2 and < 2^(PTR_W+1).
- ALIGN_LOG2, 5: preferred segment granularity, 2^ALIGN_LOG2 bytes.
- FLOW_ID_W, 8: flow identifier width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_val  in  1  request valid
- req_flow_id  in  FLOW_ID_W  flow of request
- req_trail_ptr  in  PTR_W+1  first unsent byte
- req_lead_ptr  in  PTR_W+1  one past last buffered byte
- req_window  in  PTR_W+1  peer window bytes (used only with SEG_SCHED_WINDOW_LIMIT_EN)
- req_rdy  out  1  scheduler idle, can accept a request
- seg_val  out  1  segment descriptor valid
- seg_flow_id  out  FLOW_ID_W  flow of segment
- seg_start_ptr  out  PTR_W+1  segment first byte
- seg_size  out  PTR_W+1  segment length in bytes (never 0 when seg_val)
- seg_last  out  1  final segment of the request
- seg_rdy  in  1  consumer accepts segment
- req_empty  out  1  one-cycle pulse: accepted request had nothing to send

Behaviour:
- Reset is synchronous and active-low: rst_n sampled low at a clk edge resets the block. The block has one clock.
- Reset values: state IDLE, req_rdy=1, seg_val=0, seg_last=0, req_empty=0. seg_flow_id, seg_start_ptr and seg_size reset to 0.
- States:
  - IDLE: req_rdy=1. On req_val&&req_rdy at edge N:
    - latch flow, cur_ptr=trail, remaining=(lead-trail) mod 2^(PTR_W+1), win=window;
    - if remaining==0, go to EMPTY; else go to EMIT.
  - EMPTY: req_empty=1 for exactly one cycle (cycle N+1), no segment emitted, then return to IDLE.
  - EMIT: seg_val=1 from cycle N+1. Descriptor is registered and stays stable while seg_rdy=0.
    - On seg_val&&seg_rdy: cur_ptr+=size (wraps), remaining-=size.
    - If seg_last, go to IDLE (req_rdy=1 the following cycle); otherwise present the next descriptor in the next cycle.
    - Back-to-back sustains one segment per cycle.
- Size rule, with limit=remaining (min with win when the feature is on):
  - limit>=MSS_BYTES: MSS_BYTES;
  - limit<2^ALIGN_LOG2: limit;
  - else: limit rounded down to a multiple of 2^ALIGN_LOG2.
- seg_last=1 when size==limit, i.e. the remaining (or window-limited) bytes are exhausted after this segment.
- Arithmetic: all pointer math is modulo 2^(PTR_W+1). A request with remaining == 2^(PTR_W+1) is not representable; the caller never issues one.
- Request inputs are ignored while req_rdy=0.
- Reset mid-EMIT aborts the request: seg_val=0 in the cycle after the reset edge, no partial completion reported.

Optional Feature:
- Macro SEG_SCHED_WINDOW_LIMIT_EN.
- Defined: win tracks req_window minus bytes emitted; limit=min(remaining, win).
  - req_window==0 behaves as EMPTY: req_empty pulse, no segments.
- Undefined: req_window is unused; limit=remaining.

Decomposition:
- Shared package seg_sched_pkg:
  - state enum {IDLE, EMIT, EMPTY};
  - packed request struct (flow_id, trail, lead, window);
  - packed segment descriptor struct (flow_id, start_ptr, size, last).
- One combinational sub-module, seg_size_pick (limit, MSS, alignment to size and last), shared with the existing send pipe.

Test Plan:
- Multi-segment drain: trail=0, lead=2500, seg_rdy=1. Expect 4 back-to-back segments, then req_rdy=1:
  - (0,1024,last=0)
  - (1024,1024,0)
  - (2048,448,0)
  - (2496,4,1)
- Small request: trail=100, lead=120. Expect single segment (100,20,last=1) at cycle N+1.
- Pointer wrap: trail=0xFF00, lead=0x0500. Expect (0xFF00,1024,0) then (0x0300,512,1).
- Empty and backpressure:
  - trail=lead=0x1234: req_empty=1 for one cycle, seg_val never asserted.
  - Separately, with seg_rdy=0 for 3 cycles mid-request: descriptor held bit-stable.
- Reset mid-request: rst_n=0 one cycle during the second segment of the 2500-byte case. Expect next cycle seg_val=0, req_rdy=1, and no further segments.
- Window feature: with macro defined, lead-trail=2500 and window=600, expect (0,576,0), (576,24,1). Without the macro, expect the full 2500-byte sequence.

Source files
------------

// File: rtl/seg_sched_pkg.sv
// Shared types for the segment scheduler: FSM state, request bundle and segment descriptor.
// Struct field widths follow the default build widths of segment_scheduler.
package seg_sched_pkg;

    localparam int SEG_PTR_W     = 15;
    localparam int SEG_FLOW_ID_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        EMPTY = 2'd2
    } state_t;

    typedef struct packed {
        logic [SEG_FLOW_ID_W-1:0] flow_id;
        logic [SEG_PTR_W:0]       trail;
        logic [SEG_PTR_W:0]       lead;
        logic [SEG_PTR_W:0]       window;
    } req_t;

    typedef struct packed {
        logic [SEG_FLOW_ID_W-1:0] flow_id;
        logic [SEG_PTR_W:0]       start_ptr;
        logic [SEG_PTR_W:0]       size;
        logic                     last;
    } seg_desc_t;

endpackage

// File: rtl/seg_size_pick.sv
// Combinational segment size selection: clamp to MSS, otherwise round down to the alignment
// granule unless the limit is smaller than one granule. Shared with the send pipe.
module seg_size_pick #(
    parameter int PTR_W      = 15,
    parameter int MSS_BYTES  = 1024,
    parameter int ALIGN_LOG2 = 5
) (
    input  logic [PTR_W:0] limit,
    output logic [PTR_W:0] size,
    output logic           last
);
    localparam int             PW         = PTR_W + 1;
    localparam logic [PTR_W:0] MSS        = PW'(MSS_BYTES);
    localparam logic [PTR_W:0] ALIGN      = PW'(1) << ALIGN_LOG2;
    localparam logic [PTR_W:0] ALIGN_MASK = ~(ALIGN - 1'b1);

    function automatic logic [PTR_W:0] pick(input logic [PTR_W:0] lim);
        if (lim >= MSS) begin
            return MSS;
        end else if (lim < ALIGN) begin
            return lim;
        end else begin
            return lim & ALIGN_MASK;
        end
    endfunction

    always_comb begin
        size = pick(limit);
        last = (size == limit);
    end

endmodule

// File: rtl/segment_scheduler.sv
// Walks the outstanding byte range of one send request and emits registered segment descriptors.
// Optional SEG_SCHED_WINDOW_LIMIT_EN additionally caps the range by the peer window.
module segment_scheduler
    import seg_sched_pkg::*;
#(
    parameter int PTR_W      = SEG_PTR_W,
    parameter int MSS_BYTES  = 1024,
    parameter int ALIGN_LOG2 = 5,
    parameter int FLOW_ID_W  = SEG_FLOW_ID_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_val,
    input  logic [FLOW_ID_W-1:0] req_flow_id,
    input  logic [PTR_W:0]       req_trail_ptr,
    input  logic [PTR_W:0]       req_lead_ptr,
    input  logic [PTR_W:0]       req_window,
    output logic                 req_rdy,
    output logic                 seg_val,
    output logic [FLOW_ID_W-1:0] seg_flow_id,
    output logic [PTR_W:0]       seg_start_ptr,
    output logic [PTR_W:0]       seg_size,
    output logic                 seg_last,
    input  logic                 seg_rdy,
    output logic                 req_empty
);
    state_t         state_q, state_d;
    seg_desc_t      desc_q, desc_d;
    req_t           req_in;
    logic [PTR_W:0] rem_q, rem_d, rem_next;
    logic [PTR_W:0] limit, pick_size;
    logic           pick_last;
    logic           req_fire, load_next;

    assign req_in    = '{flow_id: req_flow_id, trail: req_trail_ptr,
                         lead: req_lead_ptr, window: req_window};
    assign req_fire  = (state_q == IDLE) && req_val;
    assign load_next = (state_q == EMIT) && seg_rdy && !desc_q.last;

    // Bytes left before picking the next segment: fresh range on accept, else minus the accepted one.
    assign rem_next = (state_q == IDLE) ? req_in.lead - req_in.trail : rem_q - desc_q.size;

`ifdef SEG_SCHED_WINDOW_LIMIT_EN
    logic [PTR_W:0] win_q, win_d, win_next;

    assign win_next = (state_q == IDLE) ? req_in.window : win_q - desc_q.size;
    assign limit    = (win_next < rem_next) ? win_next : rem_next;

    always_comb begin
        win_d = win_q;
        if (req_fire || load_next) begin
            win_d = win_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end
`else
    logic window_unused;

    assign window_unused = ^req_in.window;
    assign limit         = rem_next;
`endif

    seg_size_pick #(
        .PTR_W      (PTR_W),
        .MSS_BYTES  (MSS_BYTES),
        .ALIGN_LOG2 (ALIGN_LOG2)
    ) u_size_pick (
        .limit (limit),
        .size  (pick_size),
        .last  (pick_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            desc_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_val) state_d = (limit == '0) ? EMPTY : EMIT;
            EMIT:    if (seg_rdy && desc_q.last) state_d = IDLE;
            EMPTY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        desc_d = desc_q;
        rem_d  = rem_q;
        if (req_fire) begin
            desc_d.flow_id   = req_in.flow_id;
            desc_d.start_ptr = req_in.trail;
            desc_d.size      = pick_size;
            desc_d.last      = pick_last;
            rem_d            = rem_next;
        end else if (load_next) begin
            desc_d.start_ptr = desc_q.start_ptr + desc_q.size;
            desc_d.size      = pick_size;
            desc_d.last      = pick_last;
            rem_d            = rem_next;
        end
    end

    always_comb begin
        req_rdy   = (state_q == IDLE);
        seg_val   = (state_q == EMIT);
        req_empty = (state_q == EMPTY);
    end

    assign seg_flow_id   = desc_q.flow_id;
    assign seg_start_ptr = desc_q.start_ptr;
    assign seg_size      = desc_q.size;
    assign seg_last      = desc_q.last;

endmodule

// File: tb/tb_segment_scheduler.sv
// Scoreboard bench for segment_scheduler: directed cases plus randomized requests checked against
// a byte-range reference model. Honors SEG_SCHED_WINDOW_LIMIT_EN when defined.
module tb_segment_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_val = 1'b0;
    logic [7:0]  req_flow_id = '0;
    logic [15:0] req_trail_ptr = '0;
    logic [15:0] req_lead_ptr = '0;
    logic [15:0] req_window = '0;
    logic        req_rdy;
    logic        seg_val;
    logic [7:0]  seg_flow_id;
    logic [15:0] seg_start_ptr;
    logic [15:0] seg_size;
    logic        seg_last;
    logic        seg_rdy = 1'b1;
    logic        req_empty;

    always #5 clk = ~clk;

    segment_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_val       (req_val),
        .req_flow_id   (req_flow_id),
        .req_trail_ptr (req_trail_ptr),
        .req_lead_ptr  (req_lead_ptr),
        .req_window    (req_window),
        .req_rdy       (req_rdy),
        .seg_val       (seg_val),
        .seg_flow_id   (seg_flow_id),
        .seg_start_ptr (seg_start_ptr),
        .seg_size      (seg_size),
        .seg_last      (seg_last),
        .seg_rdy       (seg_rdy),
        .req_empty     (req_empty)
    );

    typedef struct {
        logic [7:0]  flow;
        logic [15:0] start;
        logic [15:0] size;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   exp_empty = 0;
    int   checks = 0;
    int   failures = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    task automatic check(input string name, input logic ok, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] f, input logic [15:0] s, input logic [15:0] z,
                                input logic l);
        exp_t e;
        e.flow = f; e.start = s; e.size = z; e.last = l;
        return e;
    endfunction

    // Reference: carve the byte range into segments with plain arithmetic.
    task automatic model_push(input logic [7:0] f, input logic [15:0] trail, input logic [15:0] lead,
                              input logic [15:0] win);
        int rem, w, lim, sz, ptr;
        rem = (int'(lead) - int'(trail)) & 32'hFFFF;
`ifdef SEG_SCHED_WINDOW_LIMIT_EN
        w = int'(win);
`else
        w = 1 << 20;
        if (win == 16'h0) w = 1 << 20;
`endif
        ptr = int'(trail);
        lim = (rem < w) ? rem : w;
        if (lim == 0) begin
            exp_empty++;
            return;
        end
        forever begin
            lim = (rem < w) ? rem : w;
            if (lim >= 1024) sz = 1024;
            else if (lim < 32) sz = lim;
            else sz = (lim / 32) * 32;
            exp_q.push_back(mk(f, 16'(ptr), 16'(sz), sz == lim));
            if (sz == lim) break;
            ptr = (ptr + sz) % 65536;
            rem -= sz;
            w -= sz;
        end
    endtask

    task automatic push_drain_2500(input logic [7:0] f);
        exp_q.push_back(mk(f, 16'd0,    16'd1024, 1'b0));
        exp_q.push_back(mk(f, 16'd1024, 16'd1024, 1'b0));
        exp_q.push_back(mk(f, 16'd2048, 16'd448,  1'b0));
        exp_q.push_back(mk(f, 16'd2496, 16'd4,    1'b1));
    endtask

    task automatic send_req(input logic [7:0] f, input logic [15:0] t, input logic [15:0] l,
                            input logic [15:0] w);
        int n = 0;
        while (!req_rdy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_rdy) check("req_rdy_timeout", 1'b0, "req_rdy=0 want 1 within 2000 cycles");
        req_val = 1'b1;
        req_flow_id = f; req_trail_ptr = t; req_lead_ptr = l; req_window = w;
        @(posedge clk); #1;
        req_val = 1'b0;
        req_flow_id = 8'($urandom); req_trail_ptr = 16'($urandom);
        req_lead_ptr = 16'($urandom); req_window = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(req_rdy && exp_q.size() == 0) && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(req_rdy && exp_q.size() == 0))
            check("idle_timeout", 1'b0,
                  $sformatf("req_rdy=%0b pending=%0d want 1 and 0", req_rdy, exp_q.size()));
    endtask

    always begin
        @(posedge clk); #2;
        seg_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'(($urandom_range(0, 3) != 0));
    end

    logic        prev_hold = 1'b0;
    logic [40:0] prev_desc = '0;

    // Monitor: pops the scoreboard on every accepted segment and checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                check("hold_stable",
                      seg_val && ({seg_flow_id, seg_start_ptr, seg_size, seg_last} == prev_desc),
                      $sformatf("val=%0b desc=%h want val=1 desc=%h", seg_val,
                                {seg_flow_id, seg_start_ptr, seg_size, seg_last}, prev_desc));
            if (seg_val && seg_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_seg", 1'b0,
                          $sformatf("got start=%h size=%0d with no segment expected",
                                    seg_start_ptr, seg_size));
                end else begin
                    e = exp_q.pop_front();
                    check("segment",
                          seg_flow_id == e.flow && seg_start_ptr == e.start &&
                          seg_size == e.size && seg_last == e.last,
                          $sformatf("got flow=%h start=%h size=%0d last=%0b want flow=%h start=%h size=%0d last=%0b",
                                    seg_flow_id, seg_start_ptr, seg_size, seg_last,
                                    e.flow, e.start, e.size, e.last));
                end
            end
            if (req_empty) begin
                check("empty_expected", exp_empty > 0, "req_empty=1 want 0 (no empty request pending)");
                if (exp_empty > 0) exp_empty--;
            end
            prev_hold = seg_val && !seg_rdy;
            prev_desc = {seg_flow_id, seg_start_ptr, seg_size, seg_last};
        end
    end

    initial begin
        logic [15:0] t, l, w;
        int sel;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_rdy", req_rdy == 1'b1, $sformatf("got %0b want 1", req_rdy));
        check("rst_seg_val", seg_val == 1'b0, $sformatf("got %0b want 0", seg_val));
        check("rst_req_empty", req_empty == 1'b0, $sformatf("got %0b want 0", req_empty));
        check("rst_seg_last", seg_last == 1'b0, $sformatf("got %0b want 0", seg_last));
        check("rst_desc", {seg_flow_id, seg_start_ptr, seg_size} == 40'h0,
              $sformatf("got %h want 0", {seg_flow_id, seg_start_ptr, seg_size}));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multi-segment drain with back-to-back timing.
        push_drain_2500(8'h11);
        send_req(8'h11, 16'd0, 16'd2500, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("drain_busy", req_rdy == 1'b0, $sformatf("got req_rdy=%0b want 0", req_rdy));
        @(posedge clk); #1;
        check("drain_done", req_rdy == 1'b1, $sformatf("got req_rdy=%0b want 1", req_rdy));
        wait_idle();

        // Small request appears in cycle N+1.
        exp_q.push_back(mk(8'h22, 16'd100, 16'd20, 1'b1));
        send_req(8'h22, 16'd100, 16'd120, 16'hFFFF);
        check("small_latency", seg_val == 1'b1 && seg_start_ptr == 16'd100,
              $sformatf("got val=%0b start=%0d want val=1 start=100", seg_val, seg_start_ptr));
        wait_idle();

        // Pointer wrap.
        exp_q.push_back(mk(8'h33, 16'hFF00, 16'd1024, 1'b0));
        exp_q.push_back(mk(8'h33, 16'h0300, 16'd512, 1'b1));
        send_req(8'h33, 16'hFF00, 16'h0500, 16'hFFFF);
        wait_idle();

        // Empty request: one-cycle pulse.
        exp_empty++;
        send_req(8'h44, 16'h1234, 16'h1234, 16'hFFFF);
        check("empty_pulse", req_empty == 1'b1 && seg_val == 1'b0,
              $sformatf("got empty=%0b val=%0b want 1 0", req_empty, seg_val));
        @(posedge clk); #1;
        check("empty_one_cycle", req_empty == 1'b0 && req_rdy == 1'b1,
              $sformatf("got empty=%0b rdy=%0b want 0 1", req_empty, req_rdy));
        wait_idle();

        // Backpressure with ignored requests while busy.
        push_drain_2500(8'h55);
        send_req(8'h55, 16'd0, 16'd2500, 16'hFFFF);
        rdy_mode = 2;
        req_val = 1'b1;
        repeat (3) begin
            req_trail_ptr = 16'($urandom); req_lead_ptr = 16'($urandom);
            req_flow_id = 8'($urandom);
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        rdy_mode = 0;
        wait_idle();

        // Reset during the second segment aborts the request.
        push_drain_2500(8'h66);
        send_req(8'h66, 16'd0, 16'd2500, 16'hFFFF);
        @(posedge clk); #1;
        check("abort_second_seg", seg_val == 1'b1 && seg_start_ptr == 16'd1024,
              $sformatf("got val=%0b start=%0d want 1 1024", seg_val, seg_start_ptr));
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_outputs", seg_val == 1'b0 && req_rdy == 1'b1,
              $sformatf("got val=%0b rdy=%0b want 0 1", seg_val, req_rdy));
        repeat (6) @(posedge clk);
        #1;
        check("abort_quiet", seg_val == 1'b0, $sformatf("got val=%0b want 0", seg_val));

        // Window case: limited with the feature, full drain without it.
`ifdef SEG_SCHED_WINDOW_LIMIT_EN
        exp_q.push_back(mk(8'h77, 16'd0, 16'd576, 1'b0));
        exp_q.push_back(mk(8'h77, 16'd576, 16'd24, 1'b1));
`else
        push_drain_2500(8'h77);
`endif
        send_req(8'h77, 16'd0, 16'd2500, 16'd600);
        wait_idle();

        // Randomized requests under random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            t = 16'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0) l = t;
            else if (sel == 1) l = t + 16'($urandom_range(1, 40));
            else l = t + 16'($urandom_range(41, 5000));
            w = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3000));
            model_push(8'(i), t, l, w);
            send_req(8'(i), t, l, w);
        end
        wait_idle();
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check("final_queue", exp_q.size() == 0, $sformatf("got pending=%0d want 0", exp_q.size()));
        check("final_empty", exp_empty == 0, $sformatf("got pending empty=%0d want 0", exp_empty));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
